// File: rtl/mem_sched_pkg.sv
// Shared constants and the shadow-pipeline entry used by the memory request scheduler.
package mem_sched_pkg;

  localparam int LAT    = 100;
  localparam int ADDR_W = 15;
  localparam int DATA_W = 16;
  localparam int TAG_W  = 4;

  typedef struct packed {
    logic              valid;
    logic              port;
    logic [TAG_W-1:0]  tag;
    logic [ADDR_W-1:0] addr;
  } shadow_t;

  function automatic logic addr_hit(input shadow_t e, input logic [ADDR_W-1:0] a);
    return e.valid && (e.addr == a);
  endfunction

endpackage

// File: rtl/inflight_pipe.sv
// Shadow shift register that follows every issued read through the memory latency.
// Register stage i holds the load granted i+1 cycles ago; the tail responds LAT cycles after grant.
module inflight_pipe
  import mem_sched_pkg::shadow_t;
  import mem_sched_pkg::ADDR_W;
  import mem_sched_pkg::addr_hit;
#(
  parameter int LAT = mem_sched_pkg::LAT
) (
  input  logic                           clk,
  input  logic                           clr_i,
  input  shadow_t                        entry_i,
  input  logic [ADDR_W-1:0]              probe_addr_i,
  output logic                           tail_valid_o,
  output logic                           tail_port_o,
  output logic [mem_sched_pkg::TAG_W-1:0] tail_tag_o,
  output logic                           any_valid_o,
  output logic                           hazard_o
);

  shadow_t pipe_q [LAT];
  shadow_t pipe_d [LAT];

  always_comb begin
    pipe_d[0] = entry_i;
    for (int i = 1; i < LAT; i++) pipe_d[i] = pipe_q[i-1];
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < LAT; i++) begin
      pipe_q[i] <= clr_i ? '0 : pipe_d[i];
    end
  end

  assign tail_valid_o = pipe_q[LAT-1].valid;
  assign tail_port_o  = pipe_q[LAT-1].port;
  assign tail_tag_o   = pipe_q[LAT-1].tag;

  // The entry being granted this cycle counts as in flight; the tail is already responding.
  always_comb begin
    any_valid_o = entry_i.valid;
    for (int i = 0; i < LAT-1; i++) any_valid_o = any_valid_o | pipe_q[i].valid;
  end

  // A same-cycle grant is ordered after the store, and the last two ages have sampled memory.
  always_comb begin
    hazard_o = 1'b0;
    for (int i = 0; i < LAT-2; i++) hazard_o = hazard_o | addr_hit(pipe_q[i], probe_addr_i);
  end

endmodule

// File: rtl/mem_req_scheduler.sv
// Two load ports and one store port in front of a fully pipelined LAT-cycle memory.
// Round-robin load arbitration, per-port credits, and load-before-store ordering.
module mem_req_scheduler
  import mem_sched_pkg::shadow_t;
  import mem_sched_pkg::ADDR_W;
  import mem_sched_pkg::DATA_W;
#(
  parameter int LAT     = mem_sched_pkg::LAT,
  parameter int TAG_W   = mem_sched_pkg::TAG_W,
  parameter int MAX_OUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ld0_valid,
  output logic              ld0_ready,
  input  logic [ADDR_W-1:0] ld0_addr,
  input  logic [TAG_W-1:0]  ld0_tag,
  input  logic              ld1_valid,
  output logic              ld1_ready,
  input  logic [ADDR_W-1:0] ld1_addr,
  input  logic [TAG_W-1:0]  ld1_tag,
  input  logic              st_valid,
  output logic              st_ready,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [DATA_W-1:0] st_data,
  output logic              rsp0_valid,
  output logic              rsp1_valid,
  output logic [TAG_W-1:0]  rsp_tag,
  output logic [DATA_W-1:0] rsp_data,
  output logic [ADDR_W-1:0] mem_raddr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              busy
);

  localparam int               CNT_W   = $clog2(MAX_OUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic              rr_q, rr_d;
  logic [CNT_W-1:0]  cnt0_q, cnt0_d, cnt1_q, cnt1_d;
  logic [ADDR_W-1:0] raddr_q, raddr_d;
  logic              elig0, elig1, gnt0, gnt1;
  shadow_t           new_entry;
  logic              tail_valid, tail_port, hazard, pipe_busy;
  logic [TAG_W-1:0]  tail_tag;

  // Handshake: a request transfers in any cycle where valid && ready; ready may depend
  // combinationally on valid, and responses carry no backpressure.
  assign rsp0_valid = !reset && tail_valid && !tail_port;
  assign rsp1_valid = !reset && tail_valid && tail_port;
  assign rsp_tag    = tail_tag;
  assign rsp_data   = mem_rdata;

  // A response returning this cycle frees its credit for a same-cycle grant.
  assign elig0 = !reset && ld0_valid && ((cnt0_q < CNT_MAX) || rsp0_valid);
  assign elig1 = !reset && ld1_valid && ((cnt1_q < CNT_MAX) || rsp1_valid);

  // rr_q names the port that wins the next contested cycle.
  always_comb begin
    gnt0 = elig0;
    gnt1 = elig1;
    rr_d = rr_q;
    if (elig0 && elig1) begin
      gnt0 = !rr_q;
      gnt1 = rr_q;
      rr_d = !rr_q;
    end
  end

  assign ld0_ready = gnt0;
  assign ld1_ready = gnt1;

  always_comb begin
    new_entry = '0;
    raddr_d   = raddr_q;
    if (gnt0) begin
      new_entry = '{valid: 1'b1, port: 1'b0, tag: ld0_tag, addr: ld0_addr};
      raddr_d   = ld0_addr;
    end else if (gnt1) begin
      new_entry = '{valid: 1'b1, port: 1'b1, tag: ld1_tag, addr: ld1_addr};
      raddr_d   = ld1_addr;
    end
  end

  assign mem_raddr = raddr_d;

  always_comb begin
    cnt0_d = cnt0_q;
    if (gnt0 && !rsp0_valid)      cnt0_d = cnt0_q + CNT_ONE;
    else if (!gnt0 && rsp0_valid) cnt0_d = cnt0_q - CNT_ONE;
  end

  always_comb begin
    cnt1_d = cnt1_q;
    if (gnt1 && !rsp1_valid)      cnt1_d = cnt1_q + CNT_ONE;
    else if (!gnt1 && rsp1_valid) cnt1_d = cnt1_q - CNT_ONE;
  end

  // The memory registers the write at the end of the cycle, ahead of any same-cycle read.
  assign st_ready  = !reset && st_valid && !hazard;
  assign mem_wen   = st_valid && st_ready;
  assign mem_waddr = st_addr;
  assign mem_wdata = st_data;
  assign busy      = pipe_busy;

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_q    <= 1'b0;
      cnt0_q  <= '0;
      cnt1_q  <= '0;
      raddr_q <= '0;
    end else begin
      rr_q    <= rr_d;
      cnt0_q  <= cnt0_d;
      cnt1_q  <= cnt1_d;
      raddr_q <= raddr_d;
    end
  end

  inflight_pipe #(.LAT(LAT)) u_pipe (
    .clk          (clk),
    .clr_i        (reset),
    .entry_i      (new_entry),
    .probe_addr_i (st_addr),
    .tail_valid_o (tail_valid),
    .tail_port_o  (tail_port),
    .tail_tag_o   (tail_tag),
    .any_valid_o  (pipe_busy),
    .hazard_o     (hazard)
  );

endmodule
